// File: rtl/corr_scan_pkg.sv
// corr_scan_pkg: shared state encoding, widths and default search-window limits for the raster scan controller
package corr_scan_pkg;
    localparam int COORD_W = 13;
    localparam int SCORE_W = 32;
    localparam logic [COORD_W-1:0] X_LAST_DEF = 13'd560;
    localparam logic [COORD_W-1:0] Y_LAST_DEF = 13'd400;
    localparam logic [COORD_W-1:0] STEP_DEF = 13'd4;
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        SETTLE,
        CAPTURE
    } state_t;
endpackage

// File: rtl/corr_raster_counter.sv
// corr_raster_counter: raster X/Y stepping with row wrap and end-of-sweep detection
module corr_raster_counter
    import corr_scan_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_LAST = X_LAST_DEF,
    parameter logic [COORD_W-1:0] Y_LAST = Y_LAST_DEF,
    parameter logic [COORD_W-1:0] STEP = STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    // one extra bit so a step past the top of the range still compares as beyond the limit
    logic [COORD_W:0] nx, ny;
    logic wrap;
    always_comb begin
        nx = {1'b0, x} + {1'b0, STEP};
        ny = {1'b0, y} + {1'b0, STEP};
        wrap = nx > {1'b0, X_LAST};
        last = wrap && (ny > {1'b0, Y_LAST});
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= wrap ? '0 : nx[COORD_W-1:0];
            y <= wrap ? ny[COORD_W-1:0] : y;
        end
    end
endmodule

// File: rtl/corr_scan_ctrl.sv
// corr_scan_ctrl: sweeps the correlation engine over a raster of start positions and reports the best score.
// Optional CORR_SCAN_THRESHOLD_EN adds iThreshold/oFound (best score meets threshold at sweep end).
module corr_scan_ctrl
    import corr_scan_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_LAST = X_LAST_DEF,
    parameter logic [COORD_W-1:0] Y_LAST = Y_LAST_DEF,
    parameter logic [COORD_W-1:0] STEP = STEP_DEF,
    parameter int BUSY_WAIT = 4
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    input  logic               iAbort,
    output logic [COORD_W-1:0] oXstart,
    output logic [COORD_W-1:0] oYstart,
    input  logic               iFinished,
    input  logic [SCORE_W-1:0] iScore,
    output logic               oBusy,
    output logic               oDone,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY,
    output logic [SCORE_W-1:0] oBestScore
`ifdef CORR_SCAN_THRESHOLD_EN
    ,
    input  logic [SCORE_W-1:0] iThreshold,
    output logic               oFound
`endif
);
    localparam int CW = $clog2(BUSY_WAIT + 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [SCORE_W-1:0] run_score, cap_score;
    logic [COORD_W-1:0] run_x, run_y, cap_x, cap_y, x, y;
    logic last, better, start_ok, advance;
`ifdef CORR_SCAN_THRESHOLD_EN
    logic [SCORE_W-1:0] thr;
`endif
    assign start_ok = (state == IDLE) && iStart && !iAbort;
    assign advance = (state == CAPTURE) && !iAbort;
    // strict compare keeps the earliest raster position on ties
    always_comb begin
        better = iScore > run_score;
        cap_score = better ? iScore : run_score;
        cap_x = better ? oXstart : run_x;
        cap_y = better ? oYstart : run_y;
    end
    corr_raster_counter #(.X_LAST(X_LAST), .Y_LAST(Y_LAST), .STEP(STEP)) u_raster (
        .clk(iCLK),
        .rst(iRST),
        .clear(start_ok),
        .advance(advance),
        .x(x),
        .y(y),
        .last(last)
    );
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            cnt <= '0;
            oXstart <= '0;
            oYstart <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
            oBestX <= '0;
            oBestY <= '0;
            oBestScore <= '0;
            run_score <= '0;
            run_x <= '0;
            run_y <= '0;
`ifdef CORR_SCAN_THRESHOLD_EN
            thr <= '0;
            oFound <= 1'b0;
`endif
        end else begin
            oDone <= 1'b0;
            if (iAbort) begin
                state <= IDLE;
                oBusy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (iStart) begin
                        run_score <= '0;
                        run_x <= '0;
                        run_y <= '0;
                        oBusy <= 1'b1;
                        state <= ISSUE;
`ifdef CORR_SCAN_THRESHOLD_EN
                        thr <= iThreshold;
`endif
                    end
                    ISSUE: begin
                        oXstart <= x;
                        oYstart <= y;
                        cnt <= '0;
                        state <= WAIT_BUSY;
                    end
                    // an unchanged position never drops iFinished; the held score is still valid
                    WAIT_BUSY: if (!iFinished) state <= WAIT_DONE;
                        else if (cnt == CW'(BUSY_WAIT - 1)) state <= SETTLE;
                        else cnt <= cnt + CW'(1);
                    WAIT_DONE: if (iFinished) state <= SETTLE;
                    SETTLE: state <= CAPTURE;
                    CAPTURE: begin
                        run_score <= cap_score;
                        run_x <= cap_x;
                        run_y <= cap_y;
                        state <= last ? IDLE : ISSUE;
                        if (last) begin
                            oDone <= 1'b1;
                            oBusy <= 1'b0;
                            oBestX <= cap_x;
                            oBestY <= cap_y;
                            oBestScore <= cap_score;
`ifdef CORR_SCAN_THRESHOLD_EN
                            oFound <= cap_score >= thr;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_corr_scan_ctrl.sv
// tb_corr_scan_ctrl: directed checks of corr_scan_ctrl against a small behavioural correlation engine.
module tb_corr_scan_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [12:0] xs, ys, bx, by;
    logic fin, busy, done;
    logic [31:0] score, bscore;
    int tests = 0, fails = 0;
    int mode = 0;
    int done_cnt = 0;
`ifdef CORR_SCAN_THRESHOLD_EN
    logic [31:0] thr = 32'd0;
    logic found;
`endif

    always #5 clk = ~clk;

    corr_scan_ctrl #(.X_LAST(13'd8), .Y_LAST(13'd4), .STEP(13'd4), .BUSY_WAIT(4)) dut (
        .iCLK(clk),
        .iRST(rst),
        .iStart(start),
        .iAbort(abort),
        .oXstart(xs),
        .oYstart(ys),
        .iFinished(fin),
        .iScore(score),
        .oBusy(busy),
        .oDone(done),
        .oBestX(bx),
        .oBestY(by),
        .oBestScore(bscore)
`ifdef CORR_SCAN_THRESHOLD_EN
        ,
        .iThreshold(thr),
        .oFound(found)
`endif
    );

    function automatic logic [31:0] f(input logic [12:0] x, input logic [12:0] y, input int md);
        int dx, dy;
        dx = (int'(x) > 4) ? int'(x) - 4 : 4 - int'(x);
        dy = (int'(y) > 4) ? int'(y) - 4 : 4 - int'(y);
        return (md == 1) ? 32'd500 : 32'(1000 - dx - dy);
    endfunction

    // engine: restarts on a coordinate change, runs 3 cycles, score registered while finished
    logic [12:0] ex, ey;
    logic [3:0] run;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex <= '0;
            ey <= '0;
            fin <= 1'b1;
            run <= '0;
            score <= '0;
        end else begin
            if (xs != ex || ys != ey) begin
                ex <= xs;
                ey <= ys;
                fin <= 1'b0;
                run <= 4'd3;
            end else if (run != 0) begin
                run <= run - 4'd1;
                if (run == 4'd1) fin <= 1'b1;
            end
            if (fin) score <= f(ex, ey, mode);
        end
    end

    logic [12:0] px, py;
    logic [25:0] log_q[$];
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            px <= '0;
            py <= '0;
        end else begin
            if (xs != px || ys != py) log_q.push_back({xs, ys});
            px <= xs;
            py <= ys;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    logic [25:0] exp_pos[6] = '{{13'd0, 13'd0}, {13'd4, 13'd0}, {13'd8, 13'd0},
                                {13'd0, 13'd4}, {13'd4, 13'd4}, {13'd8, 13'd4}};

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        for (int i = 0; i < 800 && done_cnt == d0; i++) @(negedge clk);
        ok = (done_cnt != d0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (xs !== 13'd0) begin fails++; $display("FAIL reset_x got %0d want 0", xs); end
        tests++; if (ys !== 13'd0) begin fails++; $display("FAIL reset_y got %0d want 0", ys); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if ({bx, by} !== 26'd0) begin fails++; $display("FAIL reset_best got %0d,%0d want 0,0", bx, by); end
        tests++; if (bscore !== 32'd0) begin fails++; $display("FAIL reset_score got %0d want 0", bscore); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small_sweep(input bit from_reset);
        int base, d0, first;
        bit ok;
        base = log_q.size();
        d0 = done_cnt;
        first = from_reset ? 1 : 0;
        mode = 0;
        pulse_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sweep_busy_rise got %b want 1", busy); end
        wait_done(d0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL sweep_timeout got no done want done"); end
        tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL sweep_done_count got %0d want 1", done_cnt - d0); end
        tests++;
        if (log_q.size() - base !== 6 - first) begin
            fails++; $display("FAIL sweep_positions got %0d want %0d", log_q.size() - base, 6 - first);
        end else begin
            for (int i = 0; i < 6 - first; i++) begin
                tests++;
                if (log_q[base + i] !== exp_pos[first + i]) begin
                    fails++; $display("FAIL sweep_pos%0d got %0d,%0d want %0d,%0d", i, log_q[base + i][25:13],
                                      log_q[base + i][12:0], exp_pos[first + i][25:13], exp_pos[first + i][12:0]);
                end
            end
        end
        tests++; if ({bx, by} !== {13'd4, 13'd4}) begin fails++; $display("FAIL sweep_best got %0d,%0d want 4,4", bx, by); end
        tests++; if (bscore !== 32'd1000) begin fails++; $display("FAIL sweep_score got %0d want 1000", bscore); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sweep_busy_fall got %b want 0", busy); end
    endtask

    task automatic test_tie();
        int d0;
        bit ok;
        d0 = done_cnt;
        mode = 1;
        pulse_start();
        wait_done(d0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL tie_timeout got no done want done"); end
        tests++; if ({bx, by} !== 26'd0) begin fails++; $display("FAIL tie_best got %0d,%0d want 0,0", bx, by); end
        tests++; if (bscore !== 32'd500) begin fails++; $display("FAIL tie_score got %0d want 500", bscore); end
    endtask

    task automatic test_abort();
        int base, d0, i;
        base = log_q.size();
        d0 = done_cnt;
        mode = 0;
        pulse_start();
        for (i = 0; i < 400 && log_q.size() < base + 3; i++) @(negedge clk);
        tests++; if (log_q.size() < base + 3) begin fails++; $display("FAIL abort_reach got %0d want 3", log_q.size() - base); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
        repeat (60) @(negedge clk);
        tests++; if (done_cnt !== d0) begin fails++; $display("FAIL abort_done got %0d want %0d", done_cnt, d0); end
        tests++; if ({bx, by} !== 26'd0) begin fails++; $display("FAIL abort_best got %0d,%0d want 0,0", bx, by); end
        tests++; if (bscore !== 32'd500) begin fails++; $display("FAIL abort_score got %0d want 500", bscore); end
        tests++; if (log_q.size() !== base + 3) begin fails++; $display("FAIL abort_stopped got %0d want 3", log_q.size() - base); end
    endtask

    task automatic test_start_abort();
        int base;
        base = log_q.size();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_abort_busy got %b want 0", busy); end
        repeat (15) @(negedge clk);
        tests++; if (log_q.size() !== base) begin fails++; $display("FAIL start_abort_issue got %0d want 0", log_q.size() - base); end
    endtask

    task automatic test_reset_mid();
        int i;
        mode = 0;
        pulse_start();
        for (i = 0; i < 100 && fin !== 1'b0; i++) @(negedge clk);
        tests++; if (fin !== 1'b0) begin fails++; $display("FAIL midrst_reach got fin=%b want 0", fin); end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++; if ({xs, ys} !== 26'd0) begin fails++; $display("FAIL midrst_pos got %0d,%0d want 0,0", xs, ys); end
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL midrst_flags got %b%b want 00", busy, done); end
        tests++; if ({bx, by} !== 26'd0) begin fails++; $display("FAIL midrst_best got %0d,%0d want 0,0", bx, by); end
        tests++; if (bscore !== 32'd0) begin fails++; $display("FAIL midrst_score got %0d want 0", bscore); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_small_sweep(1'b1);
    endtask

`ifdef CORR_SCAN_THRESHOLD_EN
    task automatic test_threshold();
        int d0;
        bit ok;
        mode = 0;
        thr = 32'd999;
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, ok);
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL thr_999 got %b want 1", found); end
        thr = 32'd1001;
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, ok);
        tests++; if (found !== 1'b0) begin fails++; $display("FAIL thr_1001 got %b want 0", found); end
    endtask
`endif

    initial begin
        test_reset();
        test_small_sweep(1'b1);
        test_small_sweep(1'b0);
        test_tie();
        test_abort();
        test_start_abort();
        test_reset_mid();
`ifdef CORR_SCAN_THRESHOLD_EN
        test_threshold();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
